// File: rtl/switch_sched_pkg.sv
// Shared definitions for the switch toggle scheduler: the switch count, the
// scheduler state encoding and the round-robin picker.
package switch_sched_pkg;

    localparam int unsigned NUM_SW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // Picks the first set bit starting at (last+1) mod 4 and wrapping; the
    // 2-bit add performs the wrap. valid=0 when nothing is pending.
    function automatic rr_pick_t rr_pick(input logic [NUM_SW-1:0] pending,
                                         input logic [1:0]        last);
        rr_pick_t   r;
        logic [1:0] cand;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 1; i <= NUM_SW; i++) begin
            cand = last + 2'(i);
            if (!r.valid && pending[cand]) begin
                r.valid = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_toggle_scheduler_if.sv
// Pin bundle between the raw push-buttons / LEDs and the scheduler.
//   i_Switch_1..4 : raw button levels, 1 = pressed
//   o_LED_1..4    : LED state, 1 = lit
//   o_Busy        : scheduler is granting or holding off
//   o_Drop        : one-cycle pulse, release lost because already pending
// master = board/stimulus side, slave = scheduler side.
interface switch_toggle_scheduler_if;

    logic i_Switch_1;
    logic i_Switch_2;
    logic i_Switch_3;
    logic i_Switch_4;
    logic o_LED_1;
    logic o_LED_2;
    logic o_LED_3;
    logic o_LED_4;
    logic o_Busy;
    logic o_Drop;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy, o_Drop
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Busy, o_Drop
    );

endinterface

// File: rtl/switch_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, stability counter and
// a registered release strobe.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   i_Raw          : raw asynchronous button level
//   o_Stable       : debounced level
//   o_Release      : one-cycle strobe when o_Stable falls 1->0
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Raw,
    output logic o_Stable,
    output logic o_Release
);

    localparam int unsigned       CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rel_q, rel_d;

    // The level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle in
    // which the synchronised input differs from the stable level.
    always_comb begin
        cnt_inc  = cnt_q + 1'b1;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_inc == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        rel_d = stable_q & ~stable_d;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= i_Raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rel_q    <= rel_d;
        end
    end

    assign o_Stable  = stable_q;
    assign o_Release = rel_q;

endmodule

// File: rtl/switch_toggle_scheduler.sv
// Turns debounced button releases into LED toggles. Releases are latched as
// sticky pending flags; a round-robin scheduler applies one toggle at a time
// followed by a hold-off so each change stays visible.
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   sw_bus         : switch inputs, LED outputs, o_Busy and o_Drop
module switch_toggle_scheduler
    import switch_sched_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned HOLD_CYCLES     = 2500000
) (
    input logic                      i_Clk,
    input logic                      i_Rst_L,
    switch_toggle_scheduler_if.slave sw_bus
);

    localparam int unsigned   HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [NUM_SW-1:0] raw;
    logic [NUM_SW-1:0] rel;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        last_q, last_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NUM_SW-1:0] pending_q, pending_d;
    logic [NUM_SW-1:0] led_q, led_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [NUM_SW-1:0] clr;
    rr_pick_t          pick;

    assign raw = {sw_bus.i_Switch_4, sw_bus.i_Switch_3,
                  sw_bus.i_Switch_2, sw_bus.i_Switch_1};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .i_Raw     (raw[i]),
            .o_Stable  (),
            .o_Release (rel[i])
        );
    end

    always_comb begin
        pick    = rr_pick(pending_q, last_q);
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        hold_d  = hold_q;
        led_d   = led_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    grant_d = pick.idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                led_d[grant_q] = ~led_q[grant_q];
                clr[grant_q]   = 1'b1;
                last_d         = grant_q;
                hold_d         = HOLD_LOAD;
                state_d        = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A release landing on the grant cycle of its own switch re-arms the
        // flag (set after clear), so it is kept rather than dropped.
        pending_d = (pending_q & ~clr) | rel;
        drop_d    = |(rel & pending_q & ~clr);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= 2'd3;
            hold_q    <= '0;
            pending_q <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign sw_bus.o_LED_1 = led_q[0];
    assign sw_bus.o_LED_2 = led_q[1];
    assign sw_bus.o_LED_3 = led_q[2];
    assign sw_bus.o_LED_4 = led_q[3];
    assign sw_bus.o_Busy  = busy_q;
    assign sw_bus.o_Drop  = drop_q;

endmodule

// File: tb/tb_switch_toggle_scheduler.sv
// Directed bench for switch_toggle_scheduler with DEBOUNCE_CYCLES=4 and
// HOLD_CYCLES=8. A release driven at step R reaches the LED at step R+9;
// successive toggles are 10 steps apart.
module tb_switch_toggle_scheduler;

    localparam int unsigned DB = 4;
    localparam int unsigned HC = 8;

    logic clk = 1'b0;
    logic rst_n;

    switch_toggle_scheduler_if sw_if ();

    switch_toggle_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .sw_bus  (sw_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int tog_cnt   [4];
    int tog_first [4];
    int tog_last  [4];
    int busy_cnt;
    int drop_cnt;
    logic [3:0] prev_led;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] leds();
        return {sw_if.o_LED_4, sw_if.o_LED_3, sw_if.o_LED_2, sw_if.o_LED_1};
    endfunction

    task automatic set_sw(input logic [3:0] m);
        sw_if.i_Switch_1 = m[0];
        sw_if.i_Switch_2 = m[1];
        sw_if.i_Switch_3 = m[2];
        sw_if.i_Switch_4 = m[3];
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            tog_cnt[i]   = 0;
            tog_first[i] = -1;
            tog_last[i]  = -1;
        end
        busy_cnt = 0;
        drop_cnt = 0;
        prev_led = leds();
    endtask

    // One clock, then observe at the falling edge; tag marks the step index.
    task automatic step_obs(input int tag);
        logic [3:0] cur;
        @(posedge clk);
        @(negedge clk);
        cur = leds();
        for (int i = 0; i < 4; i++) begin
            if (cur[i] != prev_led[i]) begin
                tog_cnt[i]++;
                if (tog_first[i] < 0) tog_first[i] = tag;
                tog_last[i] = tag;
            end
        end
        prev_led = cur;
        busy_cnt += int'(sw_if.o_Busy);
        drop_cnt += int'(sw_if.o_Drop);
    endtask

    task automatic press(input logic [3:0] m);
        set_sw(m);
        for (int i = 0; i < 10; i++) step_obs(0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        set_sw(4'b0000);
        #1;
        check_eq({tag, "_led"},  int'(leds()), 0);
        check_eq({tag, "_busy"}, int'(sw_if.o_Busy), 0);
        check_eq({tag, "_drop"}, int'(sw_if.o_Drop), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_sw(4'b0000);
        repeat (3) @(negedge clk);
        check_eq("rst_led",  int'(leds()), 0);
        check_eq("rst_busy", int'(sw_if.o_Busy), 0);
        check_eq("rst_drop", int'(sw_if.o_Drop), 0);
        rst_n = 1'b1;

        // 1: single press/release of switch 1
        clear_stats();
        press(4'b0001);
        for (int s = 0; s < 30; s++) begin
            if (s == 0) set_sw(4'b0000);
            step_obs(s + 1);
            if (s + 1 == 7) check_eq("t1_busy_pre", int'(sw_if.o_Busy), 0);
            if (s + 1 == 8) begin
                check_eq("t1_busy_grant", int'(sw_if.o_Busy), 1);
                check_eq("t1_led_pre", int'(leds()), 0);
            end
        end
        check_eq("t1_led1_at",  tog_first[0], 9);
        check_eq("t1_led1_cnt", tog_cnt[0], 1);
        check_eq("t1_other",    tog_cnt[1] + tog_cnt[2] + tog_cnt[3], 0);
        check_eq("t1_busy_len", busy_cnt, 9);
        check_eq("t1_drop",     drop_cnt, 0);
        check_eq("t1_leds",     int'(leds()), 4'b0001);

        // 2: switch 2 bounces with 3-cycle pulses
        clear_stats();
        for (int p = 0; p < 5; p++) begin
            set_sw(4'b0010);
            for (int i = 0; i < 3; i++) step_obs(0);
            set_sw(4'b0000);
            for (int i = 0; i < 3; i++) step_obs(0);
        end
        for (int i = 0; i < 20; i++) step_obs(0);
        check_eq("t2_toggles", tog_cnt[0] + tog_cnt[1] + tog_cnt[2] + tog_cnt[3], 0);
        check_eq("t2_drop",    drop_cnt, 0);
        check_eq("t2_busy",    busy_cnt, 0);
        check_eq("t2_leds",    int'(leds()), 4'b0001);

        // 3: all four released together, then 2 and 4 together
        do_reset("t3_rst");
        clear_stats();
        press(4'b1111);
        for (int s = 0; s < 60; s++) begin
            if (s == 0) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t3_led1_at", tog_first[0], 9);
        check_eq("t3_led2_at", tog_first[1], 19);
        check_eq("t3_led3_at", tog_first[2], 29);
        check_eq("t3_led4_at", tog_first[3], 39);
        check_eq("t3_cnt", tog_cnt[0] + tog_cnt[1] + tog_cnt[2] + tog_cnt[3], 4);
        check_eq("t3_busy_len", busy_cnt, 36);
        check_eq("t3_leds", int'(leds()), 4'b1111);
        clear_stats();
        press(4'b1010);
        for (int s = 0; s < 40; s++) begin
            if (s == 0) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t3b_led2_at", tog_first[1], 9);
        check_eq("t3b_led4_at", tog_first[3], 19);
        check_eq("t3b_cnt13",   tog_cnt[0] + tog_cnt[2], 0);
        check_eq("t3b_leds",    int'(leds()), 4'b0101);

        // 4: switch 3 released twice while switches 1 and 2 are serviced
        do_reset("t4_rst");
        clear_stats();
        press(4'b0111);
        for (int s = 0; s < 45; s++) begin
            if (s == 0)  set_sw(4'b0100);
            if (s == 4)  set_sw(4'b0000);
            if (s == 8)  set_sw(4'b0100);
            if (s == 14) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t4_led1_at",  tog_first[0], 9);
        check_eq("t4_led2_at",  tog_first[1], 19);
        check_eq("t4_led3_at",  tog_first[2], 29);
        check_eq("t4_led3_cnt", tog_cnt[2], 1);
        check_eq("t4_drop",     drop_cnt, 1);
        check_eq("t4_busy_len", busy_cnt, 27);
        check_eq("t4_leds",     int'(leds()), 4'b0111);

        // 5: second release of switch 3 lands on its own grant cycle
        do_reset("t5_rst");
        clear_stats();
        press(4'b0101);
        for (int s = 0; s < 45; s++) begin
            if (s == 0)  set_sw(4'b0100);
            if (s == 4)  set_sw(4'b0000);
            if (s == 8)  set_sw(4'b0100);
            if (s == 12) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t5_led1_at",    tog_first[0], 9);
        check_eq("t5_led3_first", tog_first[2], 19);
        check_eq("t5_led3_last",  tog_last[2], 29);
        check_eq("t5_led3_cnt",   tog_cnt[2], 2);
        check_eq("t5_drop",       drop_cnt, 0);
        check_eq("t5_leds",       int'(leds()), 4'b0001);

        // 6: reset during HOLD with switch 4 still pending
        do_reset("t6_rst");
        clear_stats();
        press(4'b1011);
        for (int s = 0; s < 22; s++) begin
            if (s == 0) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t6_led2_at",    tog_first[1], 19);
        check_eq("t6_pre_leds",   int'(leds()), 4'b0011);
        check_eq("t6_pre_busy",   int'(sw_if.o_Busy), 1);
        do_reset("t6_async");
        clear_stats();
        press(4'b1000);
        for (int s = 0; s < 40; s++) begin
            if (s == 0) set_sw(4'b0000);
            step_obs(s + 1);
        end
        check_eq("t6_led4_at",  tog_first[3], 9);
        check_eq("t6_led4_cnt", tog_cnt[3], 1);
        check_eq("t6_other",    tog_cnt[0] + tog_cnt[1] + tog_cnt[2], 0);
        check_eq("t6_leds",     int'(leds()), 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_toggle_scheduler.md
Name: switch_toggle_scheduler

Overview:
- Debounces the four board push-buttons and turns each debounced release (1->0) into a toggle request for the matching LED.
- Queues requests as sticky pending flags.
- A round-robin scheduler applies at most one LED toggle at a time, with a hold-off period between toggles so every change stays visible.
- Sits between the raw switch pins and the LED pins at board top level.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles (10 ms at 25 MHz) required to accept a new switch level; must be >=1.
- HOLD_CYCLES, 2500000: cycles spent in HOLD after each applied toggle (100 ms at 25 MHz); must be >=1.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Switch_1..i_Switch_4  in  1 each  raw asynchronous push-button levels, 1 = pressed
- o_LED_1..o_LED_4  out  1 each  LED state, 1 = lit
- o_Busy  out  1  high while the scheduler is in GRANT or HOLD
- o_Drop  out  1  one-cycle pulse when a release arrives for a switch already pending

Behaviour:
- Reset (i_Rst_L=0, asynchronous): all LEDs 0, o_Busy 0, o_Drop 0, synchronisers/stable levels 0, debounce counters 0, pending=0, FSM=IDLE, last-grant pointer=3 (so switch 1 has top priority first).
- Synchronisation: 2-flop synchroniser per switch; only the synchronised level is used.
- Debounce, per switch:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - When synced != stable, the counter increments; when it reaches DEBOUNCE_CYCLES, stable takes the synced value and the counter clears.
  - When synced == stable, the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
- Release event: stable goes 1->0, as a registered one-cycle strobe rel[i].
  - If pending[i]=0, pending[i] is set on the next edge.
  - If pending[i]=1 and no clear happens that cycle, the event is dropped and o_Drop pulses for one cycle.
  - rel[i] in the same cycle that GRANT clears pending[i]: set wins, the event is kept and o_Drop stays 0.
- FSM states IDLE, GRANT, HOLD:
  - IDLE: if pending!=0, register grant index g = first set bit searching from (last+1) mod 4 upward with wrap, then go to GRANT. Otherwise stay in IDLE.
  - GRANT (exactly one cycle): LED[g] <= ~LED[g]; clear pending[g]; last <= g; load hold counter with HOLD_CYCLES-1; go to HOLD.
  - HOLD: decrement the counter; leave for IDLE on the cycle the counter is 0. HOLD therefore lasts HOLD_CYCLES cycles. New pending bits may set during HOLD.
- Latency: pending set at edge N with the FSM in IDLE -> GRANT at edge N+1 -> LED toggled at edge N+2.
- Back-to-back toggles are spaced exactly HOLD_CYCLES+2 cycles apart.
- o_Busy = (state != IDLE), registered with the state.
- Pending flags are never lost except by reset. A reset mid-HOLD or mid-debounce discards all in-flight state; after reset, behaviour is identical to power-up.

Decomposition:
- Package switch_sched_pkg:
  - NUM_SW=4
  - state enum {IDLE, GRANT, HOLD}
  - function rr_pick(pending[3:0], last[1:0]) returning the index and a valid bit.
- Sub-module switch_debounce (parameter DEBOUNCE_CYCLES; ports i_Clk, i_Rst_L, i_Raw, o_Stable, o_Release): 2-flop sync + counter + release strobe, instantiated 4 times.
- The top holds the pending register, the FSM, the hold counter and the LED registers.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
1. Press switch 1 for 10 cycles, then release -> exactly one toggle, LED1 0->1, two cycles after pending[0] sets; o_Busy high for 9 cycles; LED2-4 stay 0.
2. Switch 2 bounces with 3-cycle pulses repeated 5 times, then stays low -> no pending set, all LEDs unchanged, o_Drop never pulses.
3. All four switches released in the same cycle from reset -> LEDs toggle in order 1,2,3,4 at 10-cycle spacing. Then simultaneous releases of switches 2 and 4 (last=3) -> LED2 then LED4, 10 cycles apart.
4. Switch 3 released twice while the FSM holds in HOLD servicing switch 1 -> one o_Drop pulse, LED3 toggles exactly once.
5. Release of switch 3 timed to coincide with its own GRANT cycle -> LED3 toggles, pending[2] remains set, and LED3 toggles again 10 cycles later.
6. i_Rst_L asserted mid-HOLD with LED1 and LED2 lit and pending=4'b1000 -> all LEDs 0, o_Busy 0 immediately (asynchronous). After deassertion and a single switch 4 release, LED4 is the only toggle.
